// File: rtl/preamble_fcs_inserter.sv
// Ethernet framing stage: wraps an upstream byte-strobe frame with preamble/SFD,
// appends the reflected CRC-32 FCS and enforces the inter-packet gap.
module preamble_fcs_inserter #(
  parameter int         PREAMBLE_BYTES = 7,
  parameter logic [7:0] SFD            = 8'hD5,
  parameter int         IFG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_enable,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_enable,
  output logic       out_sof,
  output logic       frame_done,
  output logic       overlap_err,
  output logic       busy
);

  localparam int         DEPTH    = PREAMBLE_BYTES + 1;
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_FCS,
    S_IFG
  } state_t;

  state_t           r_state, w_state_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [31:0]      r_crc, w_crc_next;
  logic [DEPTH-1:0] r_dv;
  logic [7:0]       r_db [DEPTH];
  logic             r_last_v;
  logic             r_dropping, w_dropping_next;
  logic             w_start, w_drop_start;
  logic [7:0]       w_data_next;
  logic             w_valid_next, w_sof_next, w_done_next;
  logic [3:0][7:0]  w_fcs;
  logic [1:0]       w_fcs_idx;

  // One reflected CRC-32 byte step, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  assign w_start      = in_enable & in_valid & ~r_last_v;
  assign w_drop_start = w_start & (r_state != S_IDLE);
  assign w_fcs        = ~r_crc;
  assign w_fcs_idx    = r_cnt[1:0] + 2'd1;
  assign busy         = (r_state != S_IDLE);

  always_comb begin
    w_dropping_next = r_dropping;
    if (in_enable) begin
      if (w_drop_start) begin
        w_dropping_next = 1'b1;
      end else if (!in_valid) begin
        w_dropping_next = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_crc_next   = r_crc;
    w_data_next  = out_data;
    w_valid_next = out_valid;
    w_sof_next   = out_sof;
    w_done_next  = frame_done;
    if (in_enable) begin
      w_data_next  = 8'h00;
      w_valid_next = 1'b0;
      w_sof_next   = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_next = S_PRE;
            w_cnt_next   = 8'd1;
            w_data_next  = 8'h55;
            w_valid_next = 1'b1;
            w_sof_next   = 1'b1;
          end
        end
        S_PRE: begin
          w_valid_next = 1'b1;
          if (r_cnt < PRE_LAST) begin
            w_data_next = 8'h55;
            w_cnt_next  = r_cnt + 8'd1;
          end else begin
            w_data_next  = SFD;
            w_state_next = S_DATA;
            w_crc_next   = 32'hFFFF_FFFF;
          end
        end
        S_DATA: begin
          w_valid_next = 1'b1;
          if (r_dv[DEPTH-1]) begin
            w_data_next = r_db[DEPTH-1];
            w_crc_next  = crc_byte(r_crc, r_db[DEPTH-1]);
          end else begin
            w_data_next  = w_fcs[0];
            w_state_next = S_FCS;
            w_cnt_next   = 8'd0;
          end
        end
        S_FCS: begin
          w_valid_next = 1'b1;
          w_data_next  = w_fcs[w_fcs_idx];
          w_cnt_next   = r_cnt + 8'd1;
          if (w_fcs_idx == 2'd3) begin
            w_done_next  = 1'b1;
            w_state_next = S_IFG;
            w_cnt_next   = 8'd0;
          end
        end
        S_IFG: begin
          if (r_cnt == IFG_LAST) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 8'd0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_crc       <= 32'hFFFF_FFFF;
      r_last_v    <= 1'b1;
      r_dropping  <= 1'b0;
      r_dv        <= '0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_enable  <= 1'b0;
      out_sof     <= 1'b0;
      frame_done  <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_crc       <= w_crc_next;
      r_dropping  <= w_dropping_next;
      out_data    <= w_data_next;
      out_valid   <= w_valid_next;
      out_sof     <= w_sof_next;
      frame_done  <= w_done_next;
      out_enable  <= in_enable;
      overlap_err <= w_drop_start;
      if (in_enable) begin
        r_last_v <= in_valid;
        // A dropped start's own byte is already invalidated, not just its successors.
        r_dv     <= {r_dv[DEPTH-2:0], in_valid & ~(r_dropping | w_drop_start)};
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_db[gi] <= 8'h00;
        else if (in_enable) r_db[gi] <= in_data;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_db[gi] <= 8'h00;
        else if (in_enable) r_db[gi] <= r_db[gi-1];
      end
    end
  end

endmodule

// File: tb/tb_preamble_fcs_inserter.sv
// Scoreboard bench: a frame-level model turns each strobe segment into the expected
// wire stream; a monitor pops one expectation per out_enable.
module tb_preamble_fcs_inserter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_enable = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_enable, out_sof, frame_done, overlap_err, busy;

  always #5 clk = ~clk;

  preamble_fcs_inserter dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_enable(in_enable),
    .out_data(out_data), .out_valid(out_valid), .out_enable(out_enable),
    .out_sof(out_sof), .frame_done(frame_done), .overlap_err(overlap_err),
    .busy(busy)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       sof;
    logic       done;
    logic       ovl;
  } exp_t;

  exp_t       exp_q[$];
  bit         sv_q[$];
  logic [7:0] sd_q[$];
  int         sg_q[$];
  bit         g_sparse = 1'b0;
  bit         m_last_v = 1'b1;
  int         n_vec = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  int         ovl_cnt = 0;
  logic       en_d;

  // Bit-serial CRC-32 over a whole frame, returning the transmitted FCS value.
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    return ~c;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic add_strobe(input bit v, input logic [7:0] d);
    sv_q.push_back(v);
    sd_q.push_back(d);
    sg_q.push_back(g_sparse ? 3 + int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_strobe(1'b0, 8'($urandom));
  endtask

  task automatic add_frame(input int n);
    for (int i = 0; i < n; i++) add_strobe(1'b1, 8'($urandom));
  endtask

  task automatic strobe(input bit v, input logic [7:0] d, input int gap);
    in_valid  = v;
    in_data   = d;
    in_enable = 1'b1;
    @(posedge clk);
    #1;
    in_enable = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected wire stream: a start is accepted only once the previous frame's
  // 8 + L + 4 + IFG window has fully elapsed; otherwise it is flagged and dropped.
  task automatic run_segment(input string name, input int limit);
    int   n;
    int   free_at;
    int   lim;
    exp_t ex[];
    n       = sv_q.size();
    lim     = (limit < 0) ? n : limit;
    ex      = new[n];
    free_at = 0;
    for (int t = 0; t < n; t++) ex[t] = '0;
    for (int t = 0; t < n; t++) begin
      if (sv_q[t] && !m_last_v) begin
        if (t >= free_at) begin
          logic [7:0]  fb[$];
          logic [31:0] f;
          int          len;
          len = 0;
          while (t + len < n && sv_q[t + len]) begin
            fb.push_back(sd_q[t + len]);
            len++;
          end
          f = fcs_of(fb);
          for (int k = 0; k < 8; k++) begin
            ex[t + k].v   = 1'b1;
            ex[t + k].d   = (k < 7) ? 8'h55 : 8'hD5;
            ex[t + k].sof = (k == 0);
          end
          for (int k = 0; k < len; k++) begin
            ex[t + 8 + k].v = 1'b1;
            ex[t + 8 + k].d = fb[k];
          end
          for (int k = 0; k < 4; k++) begin
            ex[t + 8 + len + k].v    = 1'b1;
            ex[t + 8 + len + k].d    = f[8*k +: 8];
            ex[t + 8 + len + k].done = (k == 3);
          end
          free_at = t + len + 24;
        end else begin
          ex[t].ovl = 1'b1;
        end
      end
      m_last_v = sv_q[t];
    end
    for (int t = 0; t < lim; t++) begin
      exp_q.push_back(ex[t]);
      strobe(sv_q[t], sd_q[t], sg_q[t]);
    end
    if (limit < 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_drain"}, exp_q.size(), 0);
      chk({name, "_idle"}, int'(busy), 0);
      $display("segment %s: %0d strobes", name, n);
    end
    sv_q.delete();
    sd_q.delete();
    sg_q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_d <= 1'b0;
    else en_d <= in_enable;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_enable !== en_d) begin
        n_vec++;
        n_fail++;
        $display("FAIL enable_lag @%0t: out_enable=%b expected %b", $time, out_enable, en_d);
      end
      if (out_enable) begin
        if (out_valid) valid_cnt++;
        if (overlap_err) ovl_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output @%0t: v=%b d=%02h with empty scoreboard", $time, out_valid, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_valid, out_data, out_sof, frame_done, overlap_err} !== e) begin
            n_fail++;
            $display("FAIL out_word @%0t: got v=%b d=%02h sof=%b done=%b ovl=%b, expected v=%b d=%02h sof=%b done=%b ovl=%b",
                     $time, out_valid, out_data, out_sof, frame_done, overlap_err,
                     e.v, e.d, e.sof, e.done, e.ovl);
          end
        end
      end else if (overlap_err) begin
        n_vec++;
        n_fail++;
        $display("FAIL ovl_without_strobe @%0t: overlap_err=1 expected 0", $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_outputs", int'({out_data, out_valid, out_enable, out_sof, frame_done, overlap_err, busy}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    g_sparse = 1'b0;
    add_idle(3);
    for (int i = 0; i < 9; i++) add_strobe(1'b1, 8'h31 + 8'(i));
    add_idle(30);
    run_segment("basic", -1);

    g_sparse = 1'b1;
    add_idle(3);
    for (int i = 0; i < 9; i++) add_strobe(1'b1, 8'h31 + 8'(i));
    add_idle(30);
    run_segment("sparse", -1);

    g_sparse = 1'b0;
    add_idle(3);
    add_frame(1122);
    add_idle(30);
    valid_cnt = 0;
    run_segment("udp", -1);
    chk("udp_valid_strobes", valid_cnt, 1134);

    add_idle(3);
    add_frame(20);
    add_idle(5);
    add_frame(10);
    add_idle(20);
    add_frame(15);
    add_idle(30);
    ovl_cnt = 0;
    run_segment("overlap", -1);
    chk("overlap_pulses", ovl_cnt, 1);

    for (int s = 0; s < 6; s++) begin
      g_sparse = 1'($urandom_range(0, 1));
      add_idle(2);
      for (int f = 0; f < 4; f++) begin
        add_frame(int'($urandom_range(1, 50)));
        add_idle(int'($urandom_range(1, 40)));
      end
      add_idle(30);
      run_segment($sformatf("random%0d", s), -1);
    end

    // Reset while the frame is still streaming in; in_valid stays high across it.
    g_sparse = 1'b0;
    add_idle(3);
    add_frame(40);
    add_idle(30);
    run_segment("pre_reset", 23);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_midframe_outputs", int'({out_data, out_valid, out_enable, out_sof, frame_done, overlap_err, busy}), 0);
    exp_q.delete();
    m_last_v = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_frame(20);
    add_idle(5);
    add_frame(12);
    add_idle(30);
    valid_cnt = 0;
    run_segment("post_reset", -1);
    chk("post_reset_valid_strobes", valid_cnt, 8 + 12 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/preamble_fcs_inserter.md
# preamble_fcs_inserter

Byte-stream framing stage that sits directly downstream of the UDP packet byte generator. It consumes that generator's per-byte strobe stream (`data`, `data_valid`, `data_enable`) and emits a complete Ethernet wire frame for the nibble/PHY serialiser. The wire frame is the 7-byte preamble, the SFD, the unmodified frame bytes delayed through an 8-deep line, the 4-byte CRC-32 FCS, and an enforced inter-packet gap.

## Interface
- `PREAMBLE_BYTES`, default 7: number of 0x55 bytes before the SFD; the delay line depth is `PREAMBLE_BYTES+1`.
- `SFD`, default 8'hD5: start-of-frame delimiter byte.
- `IFG_BYTES`, default 12: minimum idle strobes after the last FCS byte.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: upstream frame byte (destination MAC first).
- `in_valid` in 1: level; marks `in_data` as a frame byte. Sampled only on `in_enable`.
- `in_enable` in 1: one-cycle byte strobe. Upstream keeps strobing between frames.
- `out_data` out 8: wire byte.
- `out_valid` out 1: TX_EN level; high from the first preamble byte through the last FCS byte.
- `out_enable` out 1: one-cycle strobe qualifying `out_data`/`out_valid`.
- `out_sof` out 1: pulses with `out_enable` on the first preamble byte.
- `frame_done` out 1: pulses with `out_enable` on the last FCS byte.
- `overlap_err` out 1: one-cycle pulse when a frame start is dropped.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Delay line.** The line is `d[0..7]`, each entry `{v, byte}`. On every `in_enable`, `d[0]` ← `{in_valid & ~dropping, in_data}` and `d[i]` ← `d[i-1]`. Entries are read before the shift.
- **Frame start.** A start is `in_enable & in_valid & ~last_v`. `last_v` holds the `in_valid` value sampled on the previous strobe.
- **FSM.** Every action below happens only on an `in_enable` strobe.
  - IDLE: `out_valid`=0, `out_data`=0. On a start: go to PRE, `cnt`=1, emit 0x55, assert `out_sof`.
  - PRE: while `cnt`<`PREAMBLE_BYTES`, emit 0x55 and increment `cnt`. Otherwise emit `SFD`, go to DATA, and initialise the CRC register to 32'hFFFFFFFF.
  - DATA: if `d[7].v`=1, emit `d[7].byte` and fold it into the CRC. If `d[7].v`=0, go to FCS, `cnt`=0, and emit FCS byte 0.
  - FCS: emit FCS bytes 1..3. On byte 3, assert `frame_done`, then go to IFG with `cnt`=0.
  - IFG: `out_valid`=0, `out_data`=0. Increment `cnt` each strobe; after `IFG_BYTES` strobes go to IDLE. A start on the strobe that completes the gap is dropped.
- **CRC-32.**
  - Polynomial 0xEDB88320, reflected, processed LSB-first, one byte per strobe.
  - Initial value 32'hFFFFFFFF; FCS = ~crc, sent low byte first (FCS byte 0 = `~crc[7:0]`).
  - Preamble and SFD bytes are excluded.
- **Overlap handling.** A start seen in any state other than IDLE sets `dropping` and pulses `overlap_err`. `dropping` clears on the first strobe with `in_valid`=0. Every byte shifted in while `dropping`=1 carries `v`=0, so a dropped frame never reaches DATA.
- **Frame length.** No padding and no truncation; frame length is upstream's responsibility.
- **Back-to-back starts.** Two starts with fewer than (frame + 12 + 12) strobes between them drop the second.

## Timing
- **Output registers.** `out_enable` is `in_enable` delayed by exactly 1 clk. `out_data`, `out_valid`, `out_sof` and `frame_done` update in that same cycle and hold between strobes. `overlap_err` pulses 1 clk after the offending strobe.
- **Latency.** Input byte N (N≥0) appears on the output `PREAMBLE_BYTES+1` strobes plus 1 clk after it was sampled. The wire frame length is 8 + L + 4 strobes for an L-byte input frame.
- **Reset values.** `out_data`=0; `out_valid`, `out_enable`, `out_sof`, `frame_done`, `overlap_err`, `busy` = 0. FSM=IDLE, all `d[i].v`=0, `dropping`=0, `cnt`=0, CRC=32'hFFFFFFFF.
- **Reset mid-operation.** `last_v` resets to 1. If reset deasserts while upstream is mid-frame, that frame's remaining bytes are ignored until `in_valid` has been seen low; no partial frame is emitted.
- **Idle strobing.** With no `in_enable`, all state holds. Gaps of any length between strobes are legal.

## Test plan
- **Basic frame.** Input the 9 bytes "123456789" (0x31..0x39) on consecutive strobes, with `in_valid` low before and after. Required output: 55×7, D5, 31..39, then 26 39 F4 CB. `out_sof` on the first byte, `frame_done` on CB, then 12 strobes with `out_valid`=0.
- **Full UDP packet.** Drive the 1122-byte stream from the upstream generator. Required: an output frame of 1134 strobes whose trailing 4 bytes match a software CRC-32 of the 1122 bytes, and `out_valid` high for exactly 1134 strobes.
- **Overlap.** Start frame B 5 strobes after frame A ends. Required: `overlap_err` pulses once, frame A is emitted intact, nothing from B is emitted, and a frame C started 30 strobes later is emitted normally.
- **Sparse strobes.** Issue `in_enable` every 4th cycle with random extra stalls. Required: the byte sequence is identical to the basic-frame case, and each `out_enable` follows its `in_enable` by exactly 1 clk.
- **Reset mid-frame.** Assert `rst_n`=0 during byte 20 of a frame while `in_valid` stays high. Required: outputs are at reset values immediately, nothing is emitted for the remainder of that frame, and the next frame (after `in_valid` has gone low) is correct with a fresh CRC.
